// File: rtl/frame_capture_ctrl_if.sv
// frame_capture_ctrl_if: control, camera-sync and status bundle for frame_capture_ctrl
// Signals: arm/frame_count_req/abort (run control), frame_valid/line_valid (camera syncs),
//   cam_en/fsin/hist_clear/hist_en (drives), frame_done/busy/frames_done/err_geom/err_timeout (status)
// Modports: master drives control and syncs, slave (the controller) drives the rest
interface frame_capture_ctrl_if;
  logic       arm;
  logic [7:0] frame_count_req;
  logic       abort;
  logic       frame_valid;
  logic       line_valid;
  logic       cam_en;
  logic       fsin;
  logic       hist_clear;
  logic       hist_en;
  logic       frame_done;
  logic       busy;
  logic [7:0] frames_done;
  logic       err_geom;
  logic       err_timeout;
  modport master (
    output arm, frame_count_req, abort, frame_valid, line_valid,
    input  cam_en, fsin, hist_clear, hist_en, frame_done, busy, frames_done, err_geom, err_timeout
  );
  modport slave (
    input  arm, frame_count_req, abort, frame_valid, line_valid,
    output cam_en, fsin, hist_clear, hist_en, frame_done, busy, frames_done, err_geom, err_timeout
  );
endinterface

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: arms a camera, triggers and qualifies N frames, flags geometry and timeout errors
// Ports: clk, rst_n (asynchronous, active-low); bus (slave modport): arm/frame_count_req/abort run control,
//   frame_valid/line_valid camera syncs, cam_en/fsin/hist_clear/hist_en drives, frame_done/busy/frames_done/err_* status
module frame_capture_ctrl #(
  parameter int WIDTH    = 1920,
  parameter int HEIGHT   = 1280,
  parameter int FSIN_LEN = 4,
  parameter int TIMEOUT  = 65535
) (
  input logic clk,
  input logic rst_n,
  frame_capture_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SYNC, CAPTURE, DONE} state_t;
  state_t state, state_nx;
  logic fv_q, lv_q, pix_q, clr_q, geom_q, tmo_q;
  logic [10:0] pix_cnt, line_cnt, line_nx;
  logic [15:0] tcnt, fsin_cnt;
  logic [7:0] remaining, frames_q;
  logic fv_rise, fv_fall, lv_fall, lv_edge, active, pix, start, tmo, enter_sync, done_ok, geom_hit;
  assign fv_rise = bus.frame_valid & ~fv_q;
  assign fv_fall = ~bus.frame_valid & fv_q;
  assign lv_fall = ~bus.line_valid & lv_q;
  assign lv_edge = bus.line_valid ^ lv_q;
  assign active = state == SYNC || state == CAPTURE;
  assign start = state == IDLE && bus.arm && bus.frame_count_req != 8'd0 && !bus.abort;
  // the increment that would bring the idle count to TIMEOUT fires the timeout instead
  assign tmo = active && !lv_edge && tcnt == 16'(TIMEOUT - 1);
  assign pix = state == CAPTURE && bus.frame_valid && bus.line_valid;
  // line count including a line ending this cycle, so a coincident frame end checks the updated count
  assign line_nx = lv_fall && line_cnt != '1 ? line_cnt + 11'd1 : line_cnt;
  assign geom_hit = state == CAPTURE &&
                    ((lv_fall && pix_cnt != 11'(WIDTH)) || (fv_fall && line_nx != 11'(HEIGHT)));
  assign done_ok = state == DONE && !bus.abort;
  assign enter_sync = state_nx == SYNC && state != SYNC;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = bus.abort || tmo ? IDLE :
               state == IDLE    ? (start ? SYNC : IDLE) :
               state == SYNC    ? (fv_rise ? CAPTURE : SYNC) :
               state == CAPTURE ? (fv_fall ? DONE : CAPTURE) :
               remaining == 8'd1 ? IDLE : SYNC;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fv_q      <= 1'b0;
      lv_q      <= 1'b0;
      pix_q     <= 1'b0;
      clr_q     <= 1'b0;
      geom_q    <= 1'b0;
      tmo_q     <= 1'b0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      tcnt      <= '0;
      fsin_cnt  <= '0;
      remaining <= '0;
      frames_q  <= '0;
    end else begin
      fv_q      <= bus.frame_valid;
      lv_q      <= bus.line_valid;
      pix_q     <= pix && !bus.abort;
      clr_q     <= enter_sync;
      fsin_cnt  <= enter_sync ? 16'(FSIN_LEN) : bus.abort || tmo || fsin_cnt == 16'd0 ? '0 : fsin_cnt - 16'd1;
      tcnt      <= enter_sync || lv_edge ? '0 : active ? tcnt + 16'd1 : tcnt;
      pix_cnt   <= enter_sync || lv_fall ? '0 : pix && pix_cnt != '1 ? pix_cnt + 11'd1 : pix_cnt;
      line_cnt  <= enter_sync ? '0 : state == CAPTURE ? line_nx : line_cnt;
      geom_q    <= !start && (geom_q || (geom_hit && !bus.abort));
      tmo_q     <= !start && (tmo_q || (tmo && !bus.abort));
      remaining <= start ? bus.frame_count_req : done_ok ? remaining - 8'd1 : remaining;
      frames_q  <= start ? '0 : done_ok ? frames_q + 8'd1 : frames_q;
    end
  always_comb begin
    bus.cam_en      = state != IDLE && !bus.abort;
    bus.fsin        = fsin_cnt != 16'd0 && !bus.abort;
    bus.hist_clear  = clr_q;
    bus.hist_en     = pix_q && !bus.abort;
    bus.frame_done  = done_ok;
    bus.busy        = state != IDLE;
    bus.frames_done = frames_q;
    bus.err_geom    = geom_q;
    bus.err_timeout = tmo_q;
  end
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb_frame_capture_ctrl: directed frames with a frame_done scoreboard plus direct status checks
module tb_frame_capture_ctrl;
  localparam int W = 8;
  localparam int H = 4;
  typedef struct {int frames_before; int hist; int fsin; int geom;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int hcnt = 0;
  int fcnt = 0;
  frame_capture_ctrl_if b();
  frame_capture_ctrl #(.WIDTH(W), .HEIGHT(H), .FSIN_LEN(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic arm_run(input int n);
    b.frame_count_req = 8'(n);
    b.arm = 1'b1;
    tick();
    b.arm = 1'b0;
    b.frame_count_req = 8'd0;
  endtask
  task automatic push(input int fb, input int hist, input int geom);
    exp_t e;
    e.frames_before = fb;
    e.hist = hist;
    e.fsin = 4;
    e.geom = geom;
    sb.push_back(e);
  endtask
  task automatic send_frame(input int short_line);
    b.frame_valid = 1'b1;
    tick();
    tick();
    for (int l = 0; l < H; l++) begin
      b.line_valid = 1'b1;
      repeat (l == short_line ? W - 1 : W) tick();
      b.line_valid = 1'b0;
      tick();
      tick();
    end
    b.frame_valid = 1'b0;
    repeat (5) tick();
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(b.busy), 0);
    chk({tag, "_cam_en"}, int'(b.cam_en), 0);
    chk({tag, "_fsin"}, int'(b.fsin), 0);
    chk({tag, "_hist_en"}, int'(b.hist_en), 0);
    chk({tag, "_hist_clear"}, int'(b.hist_clear), 0);
    chk({tag, "_frame_done"}, int'(b.frame_done), 0);
    chk({tag, "_frames_done"}, int'(b.frames_done), 0);
    chk({tag, "_err_geom"}, int'(b.err_geom), 0);
    chk({tag, "_err_timeout"}, int'(b.err_timeout), 0);
  endtask
  always @(negedge clk) begin
    if (b.hist_clear) begin
      hcnt = 0;
      fcnt = 0;
    end
    if (b.hist_en) hcnt++;
    if (b.fsin) fcnt++;
    if (b.frame_done) begin
      chk("frame_done_expected", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("frames_done_at_pulse", int'(b.frames_done), e.frames_before);
        chk("hist_en_cycles", hcnt, e.hist);
        chk("fsin_cycles", fcnt, e.fsin);
        chk("err_geom_at_pulse", int'(b.err_geom), e.geom);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    b.arm = 1'b0;
    b.frame_count_req = 8'd0;
    b.abort = 1'b0;
    b.frame_valid = 1'b0;
    b.line_valid = 1'b0;
    #1;
    chk_idle_outputs("reset");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    // two clean frames
    push(0, W * H, 0);
    push(1, W * H, 0);
    arm_run(2);
    repeat (3) tick();
    send_frame(-1);
    send_frame(-1);
    chk("run2_busy", int'(b.busy), 0);
    chk("run2_frames_done", int'(b.frames_done), 2);
    chk("run2_err_geom", int'(b.err_geom), 0);
    chk("run2_err_timeout", int'(b.err_timeout), 0);
    // third line one pixel short
    push(0, W * H - 1, 1);
    arm_run(1);
    repeat (3) tick();
    send_frame(2);
    chk("short_busy", int'(b.busy), 0);
    chk("short_frames_done", int'(b.frames_done), 1);
    chk("short_err_geom", int'(b.err_geom), 1);
    // no frame arrives
    arm_run(1);
    chk("tmo_err_geom_cleared", int'(b.err_geom), 0);
    repeat (63) tick();
    chk("tmo_flag_before", int'(b.err_timeout), 0);
    chk("tmo_busy_before", int'(b.busy), 1);
    tick();
    chk("tmo_flag_at_64", int'(b.err_timeout), 1);
    chk("tmo_busy_after", int'(b.busy), 0);
    chk("tmo_frames_done", int'(b.frames_done), 0);
    // armed mid-frame: that frame is skipped
    b.frame_valid = 1'b1;
    tick();
    tick();
    arm_run(1);
    chk("skip_err_timeout_cleared", int'(b.err_timeout), 0);
    b.line_valid = 1'b1;
    repeat (W) tick();
    b.line_valid = 1'b0;
    tick();
    tick();
    b.frame_valid = 1'b0;
    repeat (4) tick();
    chk("skip_still_busy", int'(b.busy), 1);
    push(0, W * H, 0);
    send_frame(-1);
    chk("skip_busy", int'(b.busy), 0);
    chk("skip_frames_done", int'(b.frames_done), 1);
    chk("skip_err_geom", int'(b.err_geom), 0);
    // abort during line 2
    arm_run(1);
    repeat (3) tick();
    b.frame_valid = 1'b1;
    tick();
    tick();
    b.line_valid = 1'b1;
    repeat (W) tick();
    b.line_valid = 1'b0;
    tick();
    tick();
    b.line_valid = 1'b1;
    repeat (3) tick();
    chk("abort_hist_en_before", int'(b.hist_en), 1);
    chk("abort_cam_en_before", int'(b.cam_en), 1);
    b.abort = 1'b1;
    #1;
    chk("abort_cam_en", int'(b.cam_en), 0);
    chk("abort_hist_en", int'(b.hist_en), 0);
    tick();
    chk("abort_busy_next", int'(b.busy), 0);
    chk("abort_cam_en_next", int'(b.cam_en), 0);
    b.abort = 1'b0;
    b.line_valid = 1'b0;
    b.frame_valid = 1'b0;
    repeat (5) tick();
    chk("abort_frames_done", int'(b.frames_done), 0);
    chk("abort_err_geom", int'(b.err_geom), 0);
    // reset mid-capture
    arm_run(1);
    repeat (3) tick();
    b.frame_valid = 1'b1;
    tick();
    tick();
    b.line_valid = 1'b1;
    repeat (4) tick();
    chk("rst_cam_en_before", int'(b.cam_en), 1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    b.line_valid = 1'b0;
    b.frame_valid = 1'b0;
    tick();
    tick();
    chk("midrst_busy_held", int'(b.busy), 0);
    rst_n = 1'b1;
    repeat (2) tick();
    push(0, W * H, 0);
    arm_run(1);
    repeat (3) tick();
    send_frame(-1);
    chk("post_rst_busy", int'(b.busy), 0);
    chk("post_rst_frames_done", int'(b.frames_done), 1);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
